// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU function codes, sequencer state encoding
// and the instruction classes produced by the opcode decoder.
package cpu_pkg;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_HALT = 5'b11111;

    // Function codes shared with the datapath ALU.
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3
    } alu_op_e;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_HALT = 4'd7
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_LDI,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } instr_class_e;

endpackage

// File: rtl/control_sequencer_op_decoder.sv
// Combinational opcode decoder: classifies an opcode and selects the ALU
// function used in the execute phase.
module op_decoder
    import cpu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] opcode,
    output instr_class_e   iclass,
    output alu_op_e        alu_op
);

    // NOTE: every output gets a default before the case, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        iclass = CLS_ILLEGAL;
        alu_op = ALU_ADD;
        case (opcode)
            OP_ADD:  begin iclass = CLS_RTYPE; alu_op = ALU_ADD; end
            OP_SUB:  begin iclass = CLS_RTYPE; alu_op = ALU_SUB; end
            OP_AND:  begin iclass = CLS_RTYPE; alu_op = ALU_AND; end
            OP_OR:   begin iclass = CLS_RTYPE; alu_op = ALU_OR;  end
            OP_LDI:  iclass = CLS_LDI;
            OP_NOP:  iclass = CLS_NOP;
            OP_HALT: iclass = CLS_HALT;
            default: iclass = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer: fetch T0-T2, execute T3-T5, memory-ready
// stall in T1, retired-instruction counter and halt handling.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int CNTW = 16
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     ir,
    input  logic            mem_ready,
    input  logic            stop,
    output logic            pco,
    output logic            mari,
    output logic            incpc,
    output logic            rzi,
    output logic            read,
    output logic            mdri,
    output logic            rzlo,
    output logic            pci,
    output logic            mdro,
    output logic            iri,
    output logic            gra,
    output logic            grb,
    output logic            grc,
    output logic            rin,
    output logic            rout,
    output logic            ryi,
    output logic            cout,
    output logic [3:0]      alu_op,
    output logic            run,
    output logic            illegal,
    output logic [CNTW-1:0] instr_count
);

    state_e          state_q, state_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [OPW-1:0]  dec_opcode;
    instr_class_e    dec_class;
    alu_op_e         dec_alu;
    logic            retire;
    logic            unused_ir_bits;

    assign unused_ir_bits = ^ir[31-OPW:0];

    // T2 branches on the bus-visible IR; later phases use the latched opcode.
    assign dec_opcode = (state_q == ST_T2) ? ir[31 -: OPW] : op_q;

    op_decoder #(.OPW(OPW)) u_op_decoder (
        .opcode (dec_opcode),
        .iclass (dec_class),
        .alu_op (dec_alu)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   if (mem_ready) state_d = ST_T2;
            ST_T2: begin
                op_d = dec_opcode;
                case (dec_class)
                    CLS_RTYPE, CLS_LDI: state_d = ST_T3;
                    CLS_HALT:           state_d = ST_HALT;
                    default:            retire  = 1'b1;
                endcase
            end
            ST_T3:   state_d = ST_T4;
            ST_T4:   state_d = ST_T5;
            ST_T5:   retire  = 1'b1;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
        if (retire) state_d = stop ? ST_HALT : ST_T0;
        count_d = retire ? count_q + CNTW'(1) : count_q;
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        {pco, mari, incpc, rzi, read, mdri, rzlo, pci, mdro, iri} = '0;
        {gra, grb, grc, rin, rout, ryi, cout} = '0;
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        run     = (state_q != ST_IDLE) && (state_q != ST_HALT);
        case (state_q)
            ST_T0: {pco, mari, incpc, rzi} = 4'b1111;
            ST_T1: begin
                {read, mdri} = 2'b11;
                {rzlo, pci}  = {2{mem_ready}};
            end
            ST_T2: begin
                {mdro, iri} = 2'b11;
                illegal     = (dec_class == CLS_ILLEGAL);
            end
            ST_T3: {grb, rout, ryi} = 3'b111;
            ST_T4: begin
                rzi    = 1'b1;
                alu_op = dec_alu;
                if (dec_class == CLS_RTYPE) {grc, rout} = 2'b11;
                else                        cout = 1'b1;
            end
            ST_T5: {rzlo, gra, rin} = 3'b111;
            default: ;
        endcase
    end

    assign instr_count = count_q;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the RISC CPU that drives the datapath's register-transfer enables cycle by cycle. A Moore state machine steps fetch (T0–T2) and execute (T3–T5) phases, decodes the opcode held in the instruction register, and stalls on a memory-ready handshake. The datapath consumes every output directly.

## Interface
Parameters:
- OPW, 5, opcode width, taken from ir[31:27]
- CNTW, 16, instruction-counter width

Ports:
- clock  in  1  single system clock; all state changes on the rising edge
- clear  in  1  asynchronous active-high reset
- ir  in  32  current instruction-register contents
- mem_ready  in  1  memory read data is valid this cycle
- stop  in  1  level request to halt after the current instruction
- pco, mari, incpc, rzi  out  1  T0 enables
- read, mdri, rzlo, pci  out  1  T1 enables
- mdro, iri  out  1  T2 enables
- gra, grb, grc, rin, rout, ryi, cout  out  1  register-select and execute enables
- alu_op  out  4  ALU function: 0 ADD, 1 SUB, 2 AND, 3 OR
- run  out  1  processor running
- illegal  out  1  one-cycle pulse in T2 on an undefined opcode
- instr_count  out  CNTW  number of retired instructions

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT. Outputs are decoded from the state register, plus `mem_ready` in T1 only.
- IDLE: all outputs 0, `run` 0. The next edge goes to T0.
- T0: `pco mari incpc rzi`; `alu_op` ADD. Next state T1.
- T1: `read mdri` asserted every cycle.
  - If `mem_ready` is 0: remain in T1.
  - If `mem_ready` is 1: also assert `rzlo pci`, and go to T2.
- T2: `mdro iri`, then decode `ir[31:27]`:
  - 00011 ADD, 00100 SUB, 01010 AND, 01011 OR: go to T3.
  - 00001 LDI: go to T3.
  - 00000 NOP: retire.
  - 11111 HALT: go to HALT.
  - Any other opcode: `illegal` pulses, then the instruction retires as NOP.
- T3: `grb rout ryi`.
- T4:
  - R-type: `grc rout rzi`, with `alu_op` per opcode.
  - LDI: `cout rzi`, with `alu_op` ADD.
- T5: `rzlo gra rin`. Retire.
- Retire means `instr_count` increments by 1 on that edge. The next state is then:
  - HALT if `stop` is 1 on that edge;
  - otherwise T0.
- HALT: `run` 0, all enables 0. HALT is left only via `clear`. The HALT opcode does not increment `instr_count`.
- `run` is 1 in every state except IDLE and HALT.

## Timing
- Reset: `clear` high forces IDLE immediately (asynchronously). On reset, `instr_count` is 0 and every output is 0.
- `clear` asserted mid-instruction aborts the instruction with no retirement.
- Cycles per instruction, with `mem_ready` high in the first T1 cycle (each T1 wait cycle adds 1):
  - R-type and LDI: 6 cycles, T0 through T5.
  - NOP: 3 cycles.
- `pci` and `rzlo` are high for exactly one cycle per fetch, the cycle that exits T1. This prevents a double PC load.
- `ir` is sampled combinationally in T2–T5. The datapath loads IR at the end of T2, so decode uses the new value from T3 onward.
  - The branch out of T2 uses `ir` as it will be after the T2 edge. The datapath provides this by writing IR through the bus, which is transparent to this block.
  - Implementation rule: the block latches `ir[31:27]` into an internal opcode register at the T2 edge, and the T2 branch decodes the bus-visible `ir`.
- `instr_count` wraps from 2^CNTW−1 to 0 without saturating.
- `stop` is sampled only at retirement edges. `stop` high during T0–T4 takes no effect until retirement.
- `mem_ready` outside T1 is ignored.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants: OP_NOP, OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_HALT;
  - ALU function codes;
  - the state encoding (4-bit, IDLE = 0).
- The ALU package constants are also used by the datapath's ALU.
- Natural sub-module: `op_decoder`, a combinational block mapping an opcode to an instruction class (RTYPE, LDI, NOP, HALT, ILLEGAL) and an `alu_op`.
- The rest is one state register, the opcode latch and the counter.

## Test plan
- **Reset and first fetch.** Hold `clear` for 3 cycles, then release with `mem_ready` = 1. Required: outputs 0 during reset; IDLE, then T0 with `pco mari incpc rzi` = 1; T1 with `read mdri rzlo pci` = 1 for one cycle.
- **AND execute.** `ir` = {5'b01010, 27'b0}, `mem_ready` always 1. Required: T3 `grb rout ryi`; T4 `grc rout rzi` with `alu_op` = 2; T5 `rzlo gra rin`; `instr_count` goes 0→1 after 6 cycles.
- **Memory stall.** `mem_ready` = 0 for 4 cycles in T1, then 1. Required: `read mdri` high for 5 cycles; `pci` high only in the 5th; total instruction time 10 cycles.
- **NOP and illegal opcodes.** NOP (00000), then opcode 10101. Required: each takes 3 cycles; `illegal` pulses once, only for 10101; `instr_count` reaches 2.
- **Stop and HALT.** Raise `stop` during T3 of an ADD. Required: after T5, state is HALT, `run` = 0, `instr_count` = 1. Separately, a HALT opcode gives `run` = 0 after T2 with the count unchanged.
- **Mid-instruction clear and counter wrap.** Assert `clear` in T4: immediate IDLE and count 0. Separately, preload the count via CNTW = 2 and run 4 NOPs: count goes 3→0.
